// File: rtl/ram_arbiter_pkg.sv
// Shared widths and encodings for the two-master RAM arbiter.
package ram_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GNT_M0 = 1'b0,
    GNT_M1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/ram_arbiter_rr2.sv
// Combinational two-way picker: round-robin on ties, or m0-first when prio_mode_i is set.
module arb_rr2
  import ram_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  gnt_e last_grant_i,
  input  logic prio_mode_i,
  output gnt_e grant_o
);

  always_comb begin
    grant_o = GNT_M1;
    if (req0_i && req1_i) begin
      if (prio_mode_i) grant_o = GNT_M0;
      else             grant_o = (last_grant_i == GNT_M0) ? GNT_M1 : GNT_M0;
    end else if (req0_i) begin
      grant_o = GNT_M0;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master single-port RAM arbiter.
// state  | meaning: IDLE = wait for req | ACCESS = RAM strobed one cycle | RESP = ack winner, re-arbitrate
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int PRIO_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [SEL_W-1:0]  m0_sel,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ack,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [SEL_W-1:0]  m1_sel,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ack,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [SEL_W-1:0]  ram_sel_o,
  output logic [DATA_W-1:0] ram_data_o,
  input  logic [DATA_W-1:0] ram_data_i
);

  localparam logic PRIO_BIT = (PRIO_MODE != 0);

  state_e            state_q, state_d;
  gnt_e              last_q, last_d;
  gnt_e              cur_q, cur_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;

  logic req0_eff, req1_eff;
  gnt_e grant;

  // The master being acked this cycle is masked so the other one gets the next slot.
  assign req0_eff = m0_req && !(state_q == ST_RESP && cur_q == GNT_M0);
  assign req1_eff = m1_req && !(state_q == ST_RESP && cur_q == GNT_M1);

  arb_rr2 u_pick (
    .req0_i       (req0_eff),
    .req1_i       (req1_eff),
    .last_grant_i (last_q),
    .prio_mode_i  (PRIO_BIT),
    .grant_o      (grant)
  );

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    cur_d    = cur_q;
    we_d     = we_q;
    addr_d   = addr_q;
    sel_d    = sel_q;
    wdata_d  = wdata_q;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (req0_eff || req1_eff) begin
          state_d = ST_ACCESS;
          cur_d   = grant;
          last_d  = grant;
          if (grant == GNT_M0) begin
            we_d = m0_we; addr_d = m0_addr; sel_d = m0_sel; wdata_d = m0_wdata;
          end else begin
            we_d = m1_we; addr_d = m1_addr; sel_d = m1_sel; wdata_d = m1_wdata;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        state_d = ST_RESP;
        if (!we_q) begin
          if (cur_q == GNT_M0) rdata0_d = ram_data_i;
          else                 rdata1_d = ram_data_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      last_q   <= GNT_M1;
      cur_q    <= GNT_M0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      sel_q    <= '0;
      wdata_q  <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      cur_q    <= cur_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      sel_q    <= sel_d;
      wdata_q  <= wdata_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  // RAM bus is forced to zero outside ACCESS so a stray write strobe is impossible.
  assign ram_ce_o   = (state_q == ST_ACCESS);
  assign ram_we_o   = ram_ce_o && we_q;
  assign ram_addr_o = ram_ce_o ? addr_q  : '0;
  assign ram_sel_o  = ram_ce_o ? sel_q   : '0;
  assign ram_data_o = ram_ce_o ? wdata_q : '0;

  assign m0_ack   = (state_q == ST_RESP) && (cur_q == GNT_M0);
  assign m1_ack   = (state_q == ST_RESP) && (cur_q == GNT_M1);
  assign m0_rdata = rdata0_q;
  assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed and random checks of ram_arbiter; instance a is round-robin, instance b fixed-priority.
module tb_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        clr;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr  [2];
  logic [3:0]  sel   [2];
  logic [31:0] wdata [2];

  logic [1:0]  ack_a, ack_b;
  logic [31:0] rdata_a [2];
  logic [31:0] rdata_b [2];
  logic        ce_a, we_o_a, ce_b, we_o_b;
  logic [31:0] raddr_a, rdo_a, rdi_a, raddr_b, rdo_b, rdi_b;
  logic [3:0]  rsel_a, rsel_b;

  logic [31:0] mem_a [64];
  logic [31:0] mem_b [64];
  logic [31:0] ref_mem [64];

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  ram_arbiter #(.PRIO_MODE(0)) dut_a (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_sel(sel[0]), .m0_wdata(wdata[0]),
    .m0_ack(ack_a[0]), .m0_rdata(rdata_a[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_sel(sel[1]), .m1_wdata(wdata[1]),
    .m1_ack(ack_a[1]), .m1_rdata(rdata_a[1]),
    .ram_ce_o(ce_a), .ram_we_o(we_o_a), .ram_addr_o(raddr_a), .ram_sel_o(rsel_a),
    .ram_data_o(rdo_a), .ram_data_i(rdi_a)
  );

  ram_arbiter #(.PRIO_MODE(1)) dut_b (
    .clk(clk), .rst(rst),
    .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_sel(sel[0]), .m0_wdata(wdata[0]),
    .m0_ack(ack_b[0]), .m0_rdata(rdata_b[0]),
    .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_sel(sel[1]), .m1_wdata(wdata[1]),
    .m1_ack(ack_b[1]), .m1_rdata(rdata_b[1]),
    .ram_ce_o(ce_b), .ram_we_o(we_o_b), .ram_addr_o(raddr_b), .ram_sel_o(rsel_b),
    .ram_data_o(rdo_b), .ram_data_i(rdi_b)
  );

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] d, logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = d[8*k +: 8];
    return r;
  endfunction

  assign rdi_a = mem_a[raddr_a[7:2]];
  assign rdi_b = mem_b[raddr_b[7:2]];

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 64; i++) begin
        mem_a[i] <= init_word(i);
        mem_b[i] <= init_word(i);
      end
    end else begin
      if (ce_a && we_o_a) mem_a[raddr_a[7:2]] <= merge(mem_a[raddr_a[7:2]], rdo_a, rsel_a);
      if (ce_b && we_o_b) mem_b[raddr_b[7:2]] <= merge(mem_b[raddr_b[7:2]], rdo_b, rsel_b);
    end
  end

  task automatic nclk();
    @(negedge clk);
  endtask

  task automatic set_m(int i, logic w, logic [31:0] a, logic [3:0] s, logic [31:0] d);
    req[i] = 1'b1; we[i] = w; addr[i] = a; sel[i] = s; wdata[i] = d;
  endtask

  task automatic do_reset();
    rst = 1'b0; clr = 1'b1; req = 2'b00;
    nclk(); nclk();
    rst = 1'b1; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b1; req = 2'b00;
    nclk(); nclk();
    checks++;
    if ({ack_a, ce_a, we_o_a, raddr_a, rsel_a, rdo_a, rdata_a[0], rdata_a[1]} !== '0)
      $display("FAIL reset_a: ack=%b ce=%b we=%b addr=%h sel=%h data=%h rd0=%h rd1=%h expected all 0",
               ack_a, ce_a, we_o_a, raddr_a, rsel_a, rdo_a, rdata_a[0], rdata_a[1]);
    else passed++;
    checks++;
    if ({ack_b, ce_b, we_o_b, raddr_b, rsel_b, rdo_b, rdata_b[0], rdata_b[1]} !== '0)
      $display("FAIL reset_b: ack=%b ce=%b addr=%h expected all 0", ack_b, ce_b, raddr_b);
    else passed++;
    rst = 1'b1; clr = 1'b0;
  endtask

  task automatic test_read();
    set_m(0, 1'b0, 32'h10, 4'hF, 32'h0);
    nclk();
    checks++;
    if ({ce_a, we_o_a, ack_a, raddr_a} !== {1'b1, 1'b0, 2'b00, 32'h10})
      $display("FAIL read_access: ce=%b we=%b ack=%b addr=%h expected 1 0 00 00000010", ce_a, we_o_a, ack_a, raddr_a);
    else passed++;
    nclk();
    checks++;
    if ({ack_a, rdata_a[0]} !== {2'b01, 32'hDEADBEEF})
      $display("FAIL read_resp: ack=%b rdata=%h expected 01 deadbeef", ack_a, rdata_a[0]);
    else passed++;
    checks++;
    if ({ack_b, rdata_b[0]} !== {2'b01, 32'hDEADBEEF})
      $display("FAIL read_resp_b: ack=%b rdata=%h expected 01 deadbeef", ack_b, rdata_b[0]);
    else passed++;
    req[0] = 1'b0;
    nclk();
    checks++;
    if ({ack_a, ce_a} !== 3'b000) $display("FAIL read_idle: ack=%b ce=%b expected 00 0", ack_a, ce_a);
    else passed++;
  endtask

  task automatic test_write();
    set_m(1, 1'b1, 32'h20, 4'b0011, 32'h12345678);
    nclk();
    checks++;
    if ({ce_a, we_o_a, raddr_a, rsel_a, rdo_a} !== {1'b1, 1'b1, 32'h20, 4'b0011, 32'h12345678})
      $display("FAIL write_access: ce=%b we=%b addr=%h sel=%b data=%h expected 1 1 00000020 0011 12345678",
               ce_a, we_o_a, raddr_a, rsel_a, rdo_a);
    else passed++;
    nclk();
    checks++;
    if ({ack_a, we_o_a, ce_a, rdata_a[1]} !== {2'b10, 1'b0, 1'b0, 32'h0})
      $display("FAIL write_resp: ack=%b we=%b ce=%b rdata1=%h expected 10 0 0 00000000", ack_a, we_o_a, ce_a, rdata_a[1]);
    else passed++;
    req[1] = 1'b0;
    nclk();
    set_m(0, 1'b0, 32'h20, 4'hF, 32'h0);
    nclk(); nclk();
    checks++;
    if ({ack_a, rdata_a[0]} !== {2'b01, 32'hA5A55678})
      $display("FAIL write_readback: ack=%b rdata=%h expected 01 a5a55678", ack_a, rdata_a[0]);
    else passed++;
    req[0] = 1'b0;
    nclk();
  endtask

  task automatic test_tie();
    logic [1:0] exp;
    do_reset();
    set_m(0, 1'b0, 32'h10, 4'hF, 32'h0);
    set_m(1, 1'b0, 32'h20, 4'hF, 32'h0);
    for (int c = 1; c <= 16; c++) begin
      nclk();
      exp = (c % 2 == 1) ? 2'b00 : (((c / 2) % 2 == 1) ? 2'b01 : 2'b10);
      checks++;
      if (ack_a !== exp) $display("FAIL tie_rr_c%0d: ack=%b expected %b", c, ack_a, exp);
      else passed++;
      checks++;
      if (ack_b !== exp) $display("FAIL tie_prio_c%0d: ack=%b expected %b", c, ack_b, exp);
      else passed++;
      if (c == 2) begin
        checks++;
        if (rdata_a[0] !== 32'hDEADBEEF) $display("FAIL tie_rdata0: got %h expected deadbeef", rdata_a[0]);
        else passed++;
      end
      if (c == 4) begin
        checks++;
        if (rdata_a[1] !== 32'hA5A50008) $display("FAIL tie_rdata1: got %h expected a5a50008", rdata_a[1]);
        else passed++;
      end
      if (c == 16) req = 2'b00;
    end
    nclk();
  endtask

  task automatic test_prio_diff();
    set_m(0, 1'b0, 32'h10, 4'hF, 32'h0);
    nclk(); nclk();
    req[0] = 1'b0;
    nclk();
    req = 2'b11;
    nclk();
    checks++;
    if (raddr_a !== 32'h20) $display("FAIL rr_after_m0: addr=%h expected 00000020", raddr_a);
    else passed++;
    checks++;
    if (raddr_b !== 32'h10) $display("FAIL prio_after_m0: addr=%h expected 00000010", raddr_b);
    else passed++;
    nclk();
    checks++;
    if ({ack_a, ack_b} !== 4'b1001) $display("FAIL diff_acks: a=%b b=%b expected 10 01", ack_a, ack_b);
    else passed++;
    req = 2'b00;
    nclk();
    checks++;
    if ({ce_a, ce_b, ack_a, ack_b} !== 6'b0) $display("FAIL dropped_req: ce=%b%b ack=%b %b expected all 0", ce_a, ce_b, ack_a, ack_b);
    else passed++;
  endtask

  task automatic test_single_repeat();
    logic [2:0] exp;
    set_m(0, 1'b0, 32'h10, 4'hF, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      nclk();
      exp = {1'b0, (c % 3 == 2), (c % 3 == 1)};
      checks++;
      if ({ack_a, ce_a} !== exp) $display("FAIL repeat_c%0d: ack,ce=%b expected %b", c, {ack_a, ce_a}, exp);
      else passed++;
      if (c == 8) req[0] = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    set_m(1, 1'b0, 32'h20, 4'hF, 32'h0);
    nclk();
    checks++;
    if ({ce_a, raddr_a} !== {1'b1, 32'h20}) $display("FAIL mid_access: ce=%b addr=%h expected 1 00000020", ce_a, raddr_a);
    else passed++;
    rst = 1'b0;
    nclk();
    checks++;
    if ({ack_a, ce_a, we_o_a, raddr_a, rsel_a, rdo_a, rdata_a[0], rdata_a[1]} !== '0)
      $display("FAIL mid_reset: ack=%b ce=%b addr=%h rd1=%h expected all 0", ack_a, ce_a, raddr_a, rdata_a[1]);
    else passed++;
    rst = 1'b1; req = 2'b00;
    set_m(0, 1'b0, 32'h10, 4'hF, 32'h0);
    req = 2'b11;
    nclk();
    checks++;
    if (raddr_a !== 32'h10) $display("FAIL post_reset_tie: addr=%h expected 00000010", raddr_a);
    else passed++;
    nclk();
    checks++;
    if (ack_a !== 2'b01) $display("FAIL post_reset_ack: ack=%b expected 01", ack_a);
    else passed++;
    req = 2'b00;
    nclk(); nclk();
  endtask

  task automatic test_random();
    int wait_cnt [2];
    logic [5:0] idx;
    logic bad;
    do_reset();
    for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
    wait_cnt[0] = 0; wait_cnt[1] = 0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      nclk();
      bad = (ack_a == 2'b11) || (we_o_a && !ce_a) ||
            (!ce_a && ((raddr_a | rdo_a) != 32'h0 || rsel_a != 4'h0 || we_o_a));
      checks++;
      if (bad) $display("FAIL rand_invariant cyc %0d: ack=%b ce=%b we=%b addr=%h", cyc, ack_a, ce_a, we_o_a, raddr_a);
      else passed++;
      for (int i = 0; i < 2; i++) begin
        if (req[i]) begin
          if (ack_a[i]) begin
            idx = addr[i][7:2];
            if (we[i]) ref_mem[idx] = merge(ref_mem[idx], wdata[i], sel[i]);
            else begin
              checks++;
              if (rdata_a[i] !== ref_mem[idx])
                $display("FAIL rand_read m%0d cyc %0d: got %h expected %h", i, cyc, rdata_a[i], ref_mem[idx]);
              else passed++;
            end
            req[i] = 1'b0;
            wait_cnt[i] = 0;
          end else begin
            wait_cnt[i]++;
            if (wait_cnt[i] > 8) begin
              checks++;
              $display("FAIL rand_timeout m%0d cyc %0d: waited %0d cycles expected at most 8", i, cyc, wait_cnt[i]);
              wait_cnt[i] = 0;
            end
          end
        end
        if (!req[i] && $urandom_range(0, 2) != 0) begin
          idx = 6'($urandom_range(0, 15));
          set_m(i, 1'($urandom_range(0, 1)), 32'(idx) << 2, 4'($urandom_range(0, 15)), $urandom);
        end
      end
    end
    req = 2'b00;
    nclk(); nclk(); nclk();
  endtask

  initial begin
    rst = 1'b0; clr = 1'b1; req = 2'b00; we = 2'b00;
    for (int i = 0; i < 2; i++) begin
      addr[i] = '0; sel[i] = '0; wdata[i] = '0;
    end
    test_reset();
    test_read();
    test_write();
    test_tie();
    test_prio_diff();
    test_single_repeat();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
